// File: rtl/latch_arb_pkg.sv
// Shared types and constants for the latch write arbiter and its round-robin picker.
package latch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WRITE  = 2'd2,
    VERIFY = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/latch_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after rr_ptr wins.
module rr_pick
  import latch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PTR_W   = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               any_req
);

  logic [PTR_W-1:0] w_cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_req = 1'b0;
    w_cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // Candidate index wraps modulo NUM_REQ, which need not be a power of two.
      w_cand = PTR_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!any_req && req[w_cand]) begin
        any_req         = 1'b1;
        win_oh[w_cand]  = 1'b1;
        win_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin write sequencer sharing one latch: grant, one-cycle write, readback verify.
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic                          busy,
  output logic                          latch_enable,
  output logic [DATA_WIDTH-1:0]         latch_d,
  input  logic [DATA_WIDTH-1:0]         latch_q
);

  localparam int unsigned PTR_W = clog2(NUM_REQ);

  arb_state_t              r_state, w_state;
  logic [NUM_REQ-1:0]      r_grant, w_grant;
  logic [NUM_REQ-1:0]      r_done, w_done;
  logic [PTR_W-1:0]        r_idx, w_idx;
  logic [PTR_W-1:0]        r_ptr, w_ptr;
  logic                    r_err, w_err;
  logic                    r_en, w_en;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_d, w_d;

  logic [NUM_REQ-1:0]      w_pick_oh;
  logic [PTR_W-1:0]        w_pick_idx;
  logic                    w_any;
  logic [DATA_WIDTH-1:0]   w_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_data[g] = wr_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (r_ptr),
    .win_oh  (w_pick_oh),
    .win_idx (w_pick_idx),
    .any_req (w_any)
  );

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_idx   = r_idx;
    w_ptr   = r_ptr;
    w_d     = r_d;
    w_done  = '0;
    w_err   = 1'b0;
    w_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant = w_pick_oh;
          w_idx   = w_pick_idx;
          w_d     = w_data[w_pick_idx];
          w_state = GRANT;
        end
      end
      GRANT: begin
        // A dropped request abandons the slot without advancing the pointer.
        if (req[r_idx]) begin
          w_d     = w_data[r_idx];
          w_en    = 1'b1;
          w_state = WRITE;
        end else begin
          w_grant = '0;
          w_state = IDLE;
        end
      end
      WRITE: begin
        w_state = VERIFY;
      end
      VERIFY: begin
        w_done  = r_grant;
        w_err   = (latch_q != r_d);
        w_grant = '0;
        w_ptr   = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_d     <= '0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_done  <= w_done;
      r_idx   <= w_idx;
      r_ptr   <= w_ptr;
      r_err   <= w_err;
      r_en    <= w_en;
      r_busy  <= (w_state != IDLE);
      r_d     <= w_d;
    end
  end

  assign grant        = r_grant;
  assign done         = r_done;
  assign err          = r_err;
  assign busy         = r_busy;
  assign latch_enable = r_en;
  assign latch_d      = r_d;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic vs a transaction model.
module tb_latch_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  grant, done;
  logic        err, busy, latch_enable;
  logic [7:0]  latch_d, latch_q;
  logic        fault = 1'b0;
  logic [7:0]  latch_mem = '0;

  int n_pass = 0;
  int n_total = 0;

  latch_write_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .wr_data      (wr_data),
    .grant        (grant),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .latch_enable (latch_enable),
    .latch_d      (latch_d),
    .latch_q      (latch_q)
  );

  always #5 clock = ~clock;

  // simpleLatch: transparent while enable is high; fault forces a zero readback.
  always @(latch_enable or latch_d) if (latch_enable) latch_mem = latch_d;
  assign latch_q = fault ? 8'h00 : latch_mem;

  // Transaction-level reference: owner plus cycles elapsed since the grant.
  int         m_owner = -1;
  int         m_age = 0;
  int         m_ptr = 0;
  logic [7:0] m_d = '0;
  logic [7:0] m_mem = '0;
  logic       m_en = 1'b0;
  logic [3:0] m_done = '0;
  logic       m_err = 1'b0;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    logic [31:0] s;
    s = w >> (8 * i);
    return s[7:0];
  endfunction

  task automatic model_update(input logic rst, input logic [3:0] rq, input logic [31:0] dat,
                              input logic flt);
    logic [7:0] readback;
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_d = '0; m_en = 1'b0; m_done = '0; m_err = 1'b0;
    end else begin
      m_done = '0; m_err = 1'b0; m_en = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && rq[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        if (m_owner >= 0) begin
          m_d = byte_of(dat, m_owner);
          m_age = 1;
        end
      end else if (m_age == 1) begin
        if (rq[m_owner]) begin
          m_d = byte_of(dat, m_owner);
          m_mem = m_d;
          m_en = 1'b1;
          m_age = 2;
        end else begin
          m_owner = -1;
        end
      end else if (m_age == 2) begin
        m_age = 3;
      end else begin
        readback = flt ? 8'h00 : m_mem;
        m_done = 4'b0001 << m_owner;
        m_err = (readback != m_d);
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rq, input logic [31:0] dat,
                      input logic flt);
    reset = rst; req = rq; wr_data = dat; fault = flt;
    @(posedge clock);
    #1;
    model_update(rst, rq, dat, flt);
  endtask

  task automatic check(input string nm, input logic [3:0] eg, input logic [3:0] edn,
                       input logic eer, input logic ebs, input logic een, input logic [7:0] eld);
    n_total++;
    if (grant === eg && done === edn && err === eer && busy === ebs &&
        latch_enable === een && latch_d === eld) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got grant=%b done=%b err=%b busy=%b en=%b d=%h, want grant=%b done=%b err=%b busy=%b en=%b d=%h",
               nm, $time, grant, done, err, busy, latch_enable, latch_d,
               eg, edn, eer, ebs, een, eld);
    end
  endtask

  task automatic xstep(input string nm, input logic rst, input logic [3:0] rq,
                       input logic [31:0] dat, input logic flt,
                       input logic [3:0] eg, input logic [3:0] edn, input logic eer,
                       input logic ebs, input logic een, input logic [7:0] eld);
    step(rst, rq, dat, flt);
    check(nm, eg, edn, eer, ebs, een, eld);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] dat;
    logic [3:0]  g;
    logic [3:0]  dn;
    logic        er;
    logic        bs;
    logic        en;
    logic [7:0]  ld;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic [3:0] rq, input logic [31:0] dat,
                             input logic [3:0] g, input logic [3:0] dn, input logic er,
                             input logic bs, input logic en, input logic [7:0] ld);
    vec_t r;
    r.rst = rst; r.rq = rq; r.dat = dat; r.g = g; r.dn = dn;
    r.er = er; r.bs = bs; r.en = en; r.ld = ld;
    return r;
  endfunction

  vec_t        tbl [21];
  logic [3:0]  rq_r;
  logic [31:0] dat_r;
  logic        rst_r, flt_r;
  logic [7:0]  nb;

  initial begin
    // reset then idle
    tbl[0]  = v(1, 4'h0, 32'h0,        4'h0, 4'h0, 0, 0, 0, 8'h00);
    tbl[1]  = v(1, 4'h0, 32'h0,        4'h0, 4'h0, 0, 0, 0, 8'h00);
    tbl[2]  = v(0, 4'h0, 32'h0,        4'h0, 4'h0, 0, 0, 0, 8'h00);
    tbl[3]  = v(0, 4'h0, 32'h0,        4'h0, 4'h0, 0, 0, 0, 8'h00);
    // single write of 0x5A by requester 0
    tbl[4]  = v(0, 4'h1, 32'h5A,       4'h1, 4'h0, 0, 1, 0, 8'h5A);
    tbl[5]  = v(0, 4'h1, 32'h5A,       4'h1, 4'h0, 0, 1, 1, 8'h5A);
    tbl[6]  = v(0, 4'h1, 32'h5A,       4'h1, 4'h0, 0, 1, 0, 8'h5A);
    tbl[7]  = v(0, 4'h1, 32'h5A,       4'h0, 4'h1, 0, 0, 0, 8'h5A);
    tbl[8]  = v(0, 4'h0, 32'h5A,       4'h0, 4'h0, 0, 0, 0, 8'h5A);
    // abort in GRANT leaves the pointer at 0
    tbl[9]  = v(1, 4'h0, 32'h0,        4'h0, 4'h0, 0, 0, 0, 8'h00);
    tbl[10] = v(0, 4'h2, 32'h7700,     4'h2, 4'h0, 0, 1, 0, 8'h77);
    tbl[11] = v(0, 4'h0, 32'h7700,     4'h0, 4'h0, 0, 0, 0, 8'h77);
    tbl[12] = v(0, 4'h3, 32'h77A0,     4'h1, 4'h0, 0, 1, 0, 8'hA0);
    tbl[13] = v(0, 4'h3, 32'h77A0,     4'h1, 4'h0, 0, 1, 1, 8'hA0);
    tbl[14] = v(0, 4'h3, 32'h77A0,     4'h1, 4'h0, 0, 1, 0, 8'hA0);
    tbl[15] = v(0, 4'h3, 32'h77A0,     4'h0, 4'h1, 0, 0, 0, 8'hA0);
    tbl[16] = v(0, 4'h2, 32'h77A0,     4'h2, 4'h0, 0, 1, 0, 8'h77);
    tbl[17] = v(0, 4'h2, 32'h77A0,     4'h2, 4'h0, 0, 1, 1, 8'h77);
    tbl[18] = v(0, 4'h2, 32'h77A0,     4'h2, 4'h0, 0, 1, 0, 8'h77);
    tbl[19] = v(0, 4'h2, 32'h77A0,     4'h0, 4'h2, 0, 0, 0, 8'h77);
    tbl[20] = v(0, 4'h0, 32'h77A0,     4'h0, 4'h0, 0, 0, 0, 8'h77);

    for (int i = 0; i < 21; i++) begin
      xstep($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rq, tbl[i].dat, 1'b0,
            tbl[i].g, tbl[i].dn, tbl[i].er, tbl[i].bs, tbl[i].en, tbl[i].ld);
    end

    // contention fairness: all four held, grants rotate 0,1,2,3,0
    xstep("fair_rst", 1, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    for (int t = 0; t < 5; t++) begin
      logic [3:0] oh;
      logic [7:0] bv;
      oh = 4'b0001 << (t % 4);
      bv = 8'(8'h11 * ((t % 4) + 1));
      xstep("fair_grant", 0, 4'hF, 32'h44332211, 0, oh, 4'h0, 0, 1, 0, bv);
      xstep("fair_write", 0, 4'hF, 32'h44332211, 0, oh, 4'h0, 0, 1, 1, bv);
      xstep("fair_verify", 0, 4'hF, 32'h44332211, 0, oh, 4'h0, 0, 1, 0, bv);
      xstep("fair_done", 0, 4'hF, 32'h44332211, 0, 4'h0, oh, 0, 0, 0, bv);
    end

    // readback fault: latch returns 0x00 for 0xFF
    xstep("flt_rst", 1, 4'h0, 32'h0, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    xstep("flt_grant", 0, 4'h1, 32'hFF, 1, 4'h1, 4'h0, 0, 1, 0, 8'hFF);
    xstep("flt_write", 0, 4'h1, 32'hFF, 1, 4'h1, 4'h0, 0, 1, 1, 8'hFF);
    xstep("flt_verify", 0, 4'h1, 32'hFF, 1, 4'h1, 4'h0, 0, 1, 0, 8'hFF);
    xstep("flt_done", 0, 4'h1, 32'hFF, 1, 4'h0, 4'h1, 1, 0, 0, 8'hFF);
    xstep("flt_idle", 0, 4'h0, 32'hFF, 0, 4'h0, 4'h0, 0, 0, 0, 8'hFF);

    // reset mid-write, then arbitration restarts from pointer 0
    xstep("mrst_rst", 1, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    xstep("mrst_g0", 0, 4'h1, 32'h0201, 0, 4'h1, 4'h0, 0, 1, 0, 8'h01);
    xstep("mrst_w0", 0, 4'h1, 32'h0201, 0, 4'h1, 4'h0, 0, 1, 1, 8'h01);
    xstep("mrst_v0", 0, 4'h1, 32'h0201, 0, 4'h1, 4'h0, 0, 1, 0, 8'h01);
    xstep("mrst_d0", 0, 4'h1, 32'h0201, 0, 4'h0, 4'h1, 0, 0, 0, 8'h01);
    xstep("mrst_g1", 0, 4'h3, 32'h0201, 0, 4'h2, 4'h0, 0, 1, 0, 8'h02);
    xstep("mrst_w1", 0, 4'h3, 32'h0201, 0, 4'h2, 4'h0, 0, 1, 1, 8'h02);
    xstep("mrst_hit", 1, 4'h3, 32'h0201, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    xstep("mrst_g2", 0, 4'h3, 32'h0201, 0, 4'h1, 4'h0, 0, 1, 0, 8'h01);
    xstep("mrst_w2", 0, 4'h3, 32'h0201, 0, 4'h1, 4'h0, 0, 1, 1, 8'h01);
    xstep("mrst_v2", 0, 4'h3, 32'h0201, 0, 4'h1, 4'h0, 0, 1, 0, 8'h01);
    xstep("mrst_d2", 0, 4'h1, 32'h0201, 0, 4'h0, 4'h1, 0, 0, 0, 8'h01);

    // randomized traffic against the transaction model
    rq_r = '0; dat_r = '0;
    xstep("rnd_rst", 1, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0, 0, 8'h00);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rq_r[i] && m_done[i]) begin
          if ($urandom_range(1, 0) == 0) rq_r[i] = 1'b0;
        end else if (rq_r[i]) begin
          if ($urandom_range(19, 0) == 0) rq_r[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          rq_r[i] = 1'b1;
          nb = 8'($urandom);
          dat_r[i*8 +: 8] = nb;
        end
      end
      rst_r = ($urandom_range(49, 0) == 0);
      flt_r = ($urandom_range(7, 0) == 0);
      step(rst_r, rq_r, dat_r, flt_r);
      check("rand", (m_owner >= 0) ? (4'b0001 << m_owner) : 4'h0, m_done, m_err,
            (m_owner >= 0), m_en, m_d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Round-robin arbiter and write sequencer that shares one `simpleLatch` storage element between `NUM_REQ` requesters. It grants one requester at a time and drives the latch `enable`/data inputs for exactly one write cycle. It then reads the latch output back, checks it against the written value and returns a per-requester completion pulse with a mismatch flag. It sits between the requesting blocks and a single `simpleLatch` instance in the memory subsystem.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: latch data width.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NUM_REQ: per-requester write request, level.
- `wr_data`  in  NUM_REQ*DATA_WIDTH: requester i's data is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grant`  out  NUM_REQ: one-hot current owner; all-zero when idle.
- `done`  out  NUM_REQ: one-cycle pulse to the owner when its write completes.
- `err`  out  1: valid with `done`; 1 means readback mismatched.
- `busy`  out  1: high in any state except IDLE.
- `latch_enable`  out  1: drives the latch enable.
- `latch_d`  out  DATA_WIDTH: drives the latch data input.
- `latch_q`  in  DATA_WIDTH: latch output, used for readback.

## Operation
- FSM states: IDLE, GRANT, WRITE, VERIFY.
- **IDLE**
  - If any `req` is high, pick the winner with round-robin priority starting at `rr_ptr`.
  - Register `grant` = one-hot winner and `latch_d` = the winner's data, then go to GRANT.
  - With no request, stay in IDLE.
- **GRANT**
  - If the winner's `req` is still high, re-capture its data into `latch_d`, set `latch_enable` = 1 and go to WRITE.
  - If the winner's `req` has dropped, abort: clear `grant`, return to IDLE. No `done`, and `rr_ptr` is unchanged.
- **WRITE**
  - `latch_enable` is high for this one cycle; the latch captures at the closing edge.
  - Next state is VERIFY with `latch_enable` = 0.
  - `req` is ignored from here on; the transaction always completes.
- **VERIFY**
  - Compare `latch_q` with `latch_d`.
  - At the closing edge: pulse `done` for the owner, set `err` = (mismatch), clear `grant`, set `rr_ptr` = (winner+1) mod NUM_REQ, go to IDLE.
- Requesters hold `req` and `wr_data` stable until `done`. Data changes after GRANT are not seen.
- A requester that keeps `req` high after `done` re-enters arbitration at the next IDLE cycle, behind the other requesters.
- Reset mid-transaction: next edge forces IDLE, all outputs 0, `rr_ptr` = 0. No `done` is issued for the aborted write.

## Timing
- Reset values: `grant`=0, `done`=0, `err`=0, `busy`=0, `latch_enable`=0, `latch_d`=0, state=IDLE, `rr_ptr`=0.
- All outputs are registered.
- For a request seen in IDLE at edge k:
  - `grant`/`busy` high after edge k.
  - `latch_enable` high between edges k+1 and k+2.
  - Latch captures at edge k+2.
  - `done` is high between edges k+3 and k+4.
  - Total: 4 cycles from request sample to IDLE.
- `done` and `err` are low in every cycle except the completion cycle.
- Back-to-back requests: maximum throughput is one write per 4 cycles.
- Simultaneous requests: only the round-robin pointer decides; there are no fixed priorities.

## Structure
- Package `latch_arb_pkg`:
  - state enum (IDLE, GRANT, WRITE, VERIFY, 2 bits);
  - default `NUM_REQ`/`DATA_WIDTH` constants;
  - `clog2` helper for the `rr_ptr` width.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot winner and encoded index, plus `any_req`.
- Top level holds the FSM, the registers and the data multiplexer.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles, `req`=0 → all outputs 0 and `busy`=0 throughout.
- Single write: `req`=0001, data0=0x5A → `grant`=0001 for 3 cycles; `latch_enable` pulsed once with `latch_d`=0x5A; `done`=0001 with `err`=0 at k+3; latch holds 0x5A.
- Contention fairness: `req`=1111 held continuously, distinct data 0x11/0x22/0x33/0x44 → grant order 0,1,2,3,0 with one write every 4 cycles; each `done` carries `err`=0.
- Abort in GRANT: `req`=0010 for one cycle only → `grant`=0010 for one cycle; no `latch_enable`, no `done`; `rr_ptr` unchanged (next `req`=0011 grants 0 first).
- Readback fault: latch model forced to return 0x00 for `latch_d`=0xFF → `done` pulse with `err`=1; the FSM still returns to IDLE.
- Reset mid-write: assert `reset` during WRITE → all outputs 0 next cycle; no `done`; the next request is arbitrated from `rr_ptr`=0.
